tea_cbc_ctrl: RTL and testbench
===============================

// Module: tea_cbc_ctrl
// PURPOSE
//  Block-mode controller sitting directly upstream of the TEA core (dut). It accepts a 32-bit
//  word stream, packs word pairs into 64-bit blocks and drives the core's start and V0/V1 inputs.
//  It answers the core's key-address requests from an internal 4x32 key file, captures oC0/oC1 on
//  oDone, applies CBC chaining and returns result words on a valid/ready output stream.
// PARAMETERS
//  WORD_SIZE     32  data/key word width; the core uses the same value
//  ROUND_NUMBER  32  core rounds; sets the watchdog limit
//  WDOG_SLACK    16  extra cycles allowed beyond 4*ROUND_NUMBER before a timeout is declared
// PORTS
//  clk           in   1          single clock, rising edge
//  rst           in   1          asynchronous, active-low reset
//  iKeyWe        in   1          key-file write strobe; ignored unless state==IDLE
//  iKeyAddr      in   2          key-file write index
//  iKeyData      in   WORD_SIZE  key word
//  iIvLoad       in   1          loads chain register from {iIv0,iIv1}; ignored unless IDLE
//  iIv0/iIv1     in   WORD_SIZE  initial vector halves
//  iMode         in   1          0=encrypt, 1=decrypt; sampled on the first accepted word of a block
//  iInValid      in   1          input word valid
//  iInData       in   WORD_SIZE  input word; first word of a pair -> V0, second -> V1
//  oInReady      out  1          high in GET0/GET1 only
//  oOutValid     out  1          result word valid (PUT0/PUT1)
//  oOutData      out  WORD_SIZE  result word; C0 first, then C1
//  iOutReady     in   1          downstream accept
//  oV0/oV1       out  WORD_SIZE  to core iV0/iV1
//  oStartCipher  out  1          to core iStartCipher
//  oStartDecipher out 1          to core iStartDecipher
//  iKeyAddress   in   2          from core oKey_address
//  oKeySub       out  WORD_SIZE  to core iKey_sub_i; combinational read key[iKeyAddress]
//  iC0/iC1       in   WORD_SIZE  from core oC0/oC1
//  iCoreDone     in   1          from core oDone
//  oBusy         out  1          state != IDLE
//  oError        out  1          sticky watchdog timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset: every output and register is 0, key file and chain register included; state=IDLE.
//  FSM: IDLE -(iInValid)-> GET0; GET0 -(handshake)-> GET1; GET1 -(handshake)-> RUN;
//   RUN -(iCoreDone)-> PUT0; PUT0 -(handshake)-> PUT1; PUT1 -(handshake)-> DRAIN;
//   DRAIN -(!iCoreDone)-> IDLE, or GET0 if iInValid; any state -(watchdog)-> ERR.
//   ERR is terminal: oError=1, oInReady=0, oOutValid=0, starts=0, until reset.
//  Handshake: a transfer happens on a clock edge where valid&&ready; data is held stable while
//   valid is high and ready is low. Back-to-back words are accepted with no bubble.
//  Input prep, registered at the GET1 handshake: enc: {oV0,oV1}={w0,w1}^chain;
//   dec: {oV0,oV1}={w0,w1}. Raw {w0,w1} is kept in hold register H.
//  RUN: the matching start (cipher if mode=0, else decipher) is held high from the first RUN
//   cycle until the cycle iCoreDone is seen, then drops. {iC0,iC1} is captured on that edge.
//   Result: enc R=C, chain<=C; dec R=C^chain, chain<=H.
//  DRAIN waits for the core to drop oDone, so a stale done is never taken as a new completion.
//  Watchdog: counter cleared on RUN entry; if it reaches 4*ROUND_NUMBER+WDOG_SLACK in RUN or
//   DRAIN, go to ERR. Counter width is clog2 of the limit + 1 and it does not wrap.
//  Key/IV writes outside IDLE are dropped silently. If iKeyWe and iIvLoad are both high in IDLE,
//   both take effect. If iIvLoad and the first iInValid occur together, the IV is loaded and the
//   word is accepted in the next cycle.
//  Async reset mid-block aborts the operation and drops all starts immediately.
// CONFIGURATION
//  TEA_CBC_CHAIN_EN defined: CBC chaining as described above.
//  Undefined: ECB. Chain XOR is removed, chain register and iIvLoad are unused, and R=C in both
//   modes. Ports are unchanged.
// STRUCTURE
//  Package tea_pkg: FSM state enum; TEA_DELTA=32'h9e3779b9; default WORD_SIZE and ROUND_NUMBER;
//   watchdog-limit function.
//  Sub-module tea_key_file: 4xWORD_SIZE regs, one write port, one async read port.
//   The rest is flat.
// TESTING
//  Reference model: C TEA, 32 rounds.
//  1. ECB enc, key {132acf42,234acb45,3235acbe,4533f235}, words 3d45f7a7,235fcb21
//     -> outputs match the model, oError=0.
//  2. Same block, CBC, IV=0 -> identical to scenario 1. IV=1 -> equals ECB of {3d45f7a7,235fcb21^1}.
//  3. Encrypt 3 blocks with CBC, then decrypt the 3 ciphertexts with the same IV
//     -> original 6 words return in order.
//  4. iOutReady low for 20 cycles in PUT0 -> oOutData stable and oInReady=0; no word lost or duplicated.
//  5. iKeyWe while oBusy -> key file unchanged; next block still matches the original key.
//  6. Core model never asserts done -> oError=1 at RUN entry+4*32+16 cycles; rst low -> all outputs 0.

Source files
------------

// File: rtl/tea_cbc_ctrl_pkg.sv
// Shared types and constants for the TEA block-mode controller.
package tea_pkg;
  localparam int          WORD_SIZE_DEF    = 32;
  localparam int          ROUND_NUMBER_DEF = 32;
  localparam logic [31:0] TEA_DELTA        = 32'h9e3779b9;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GET0, ST_GET1, ST_RUN, ST_PUT0, ST_PUT1, ST_DRAIN, ST_ERR
  } state_e;

  // Cycles a block may spend in RUN/DRAIN before the core is declared hung.
  function automatic int wdog_limit(input int rounds, input int slack);
    return 4 * rounds + slack;
  endfunction
endpackage

// File: rtl/tea_cbc_ctrl_if.sv
// Word-stream input and result-stream output of the TEA block-mode controller.
interface tea_cbc_ctrl_if
  import tea_pkg::*;
#(parameter int WORD_SIZE = WORD_SIZE_DEF);
  logic                 iInValid;
  logic [WORD_SIZE-1:0] iInData;
  logic                 oInReady;
  logic                 oOutValid;
  logic [WORD_SIZE-1:0] oOutData;
  logic                 iOutReady;

  modport master (output iInValid, iInData, iOutReady,
                  input  oInReady, oOutValid, oOutData);
  modport slave  (input  iInValid, iInData, iOutReady,
                  output oInReady, oOutValid, oOutData);
endinterface

// File: rtl/tea_cbc_ctrl_key_file.sv
// 4-entry key file: one synchronous write port, one combinational read port for the core.
module tea_key_file
  import tea_pkg::*;
#(parameter int WORD_SIZE = WORD_SIZE_DEF) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [1:0]           waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [1:0]           raddr,
  output logic [WORD_SIZE-1:0] rdata
);
  logic [3:0][WORD_SIZE-1:0] key;

  always_ff @(posedge clk or negedge rst)
    if (!rst)    key <= '0;
    else if (we) key[waddr] <= wdata;

  assign rdata = key[raddr];
endmodule

// File: rtl/tea_cbc_ctrl.sv
// Block-mode controller in front of a TEA core: packs word pairs, drives the core, chains results.
// TEA_CBC_CHAIN_EN selects CBC chaining; without it the block runs ECB and ignores the IV inputs.
module tea_cbc_ctrl
  import tea_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int ROUND_NUMBER = ROUND_NUMBER_DEF,
  parameter int WDOG_SLACK   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iKeyWe,
  input  logic [1:0]           iKeyAddr,
  input  logic [WORD_SIZE-1:0] iKeyData,
  input  logic                 iIvLoad,
  input  logic [WORD_SIZE-1:0] iIv0,
  input  logic [WORD_SIZE-1:0] iIv1,
  input  logic                 iMode,
  tea_cbc_ctrl_if.slave        s,
  output logic [WORD_SIZE-1:0] oV0,
  output logic [WORD_SIZE-1:0] oV1,
  output logic                 oStartCipher,
  output logic                 oStartDecipher,
  input  logic [1:0]           iKeyAddress,
  output logic [WORD_SIZE-1:0] oKeySub,
  input  logic [WORD_SIZE-1:0] iC0,
  input  logic [WORD_SIZE-1:0] iC1,
  input  logic                 iCoreDone,
  output logic                 oBusy,
  output logic                 oError
);
  localparam int LIMIT = wdog_limit(ROUND_NUMBER, WDOG_SLACK);
  localparam int CW    = $clog2(LIMIT) + 1;
  localparam int BW    = 2 * WORD_SIZE;

  state_e               state, state_nx;
  logic                 mode, in_hs, out_hs, wdog_hit;
  logic [WORD_SIZE-1:0] w0, r0, r1;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        chain_x, res;

  assign in_hs    = s.iInValid && s.oInReady;
  assign out_hs   = s.oOutValid && s.iOutReady;
  assign wdog_hit = (state == ST_RUN || state == ST_DRAIN) && (cnt == CW'(LIMIT - 1));

  tea_key_file #(.WORD_SIZE(WORD_SIZE)) u_key (
    .clk   (clk),
    .rst   (rst),
    .we    (iKeyWe && state == ST_IDLE),
    .waddr (iKeyAddr),
    .wdata (iKeyData),
    .raddr (iKeyAddress),
    .rdata (oKeySub)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (s.iInValid) state_nx = ST_GET0;
      ST_GET0:  if (in_hs)      state_nx = ST_GET1;
      ST_GET1:  if (in_hs)      state_nx = ST_RUN;
      ST_RUN:   if (iCoreDone)  state_nx = ST_PUT0;
      ST_PUT0:  if (out_hs)     state_nx = ST_PUT1;
      ST_PUT1:  if (out_hs)     state_nx = ST_DRAIN;
      // the core must release done before another block may start
      ST_DRAIN: if (!iCoreDone) state_nx = s.iInValid ? ST_GET0 : ST_IDLE;
      default:                  state_nx = ST_ERR;
    endcase
    if (wdog_hit) state_nx = ST_ERR;
  end

  always_comb begin
    s.oInReady     = (state == ST_GET0) || (state == ST_GET1);
    s.oOutValid    = (state == ST_PUT0) || (state == ST_PUT1);
    s.oOutData     = (state == ST_PUT0) ? r0 : (state == ST_PUT1) ? r1 : '0;
    oStartCipher   = (state == ST_RUN) && !mode;
    oStartDecipher = (state == ST_RUN) && mode;
    oBusy          = (state != ST_IDLE);
    oError         = (state == ST_ERR);
  end

`ifdef TEA_CBC_CHAIN_EN
  logic [BW-1:0] chain, hold;

  assign chain_x = mode ? '0 : chain;
  assign res     = mode ? ({iC0, iC1} ^ chain) : {iC0, iC1};

  // enc chains on the ciphertext, dec chains on the raw input block
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      chain <= '0;
      hold  <= '0;
    end else begin
      if (state == ST_IDLE && iIvLoad)     chain <= {iIv0, iIv1};
      else if (state == ST_RUN && iCoreDone) chain <= mode ? hold : {iC0, iC1};
      if (state == ST_GET1 && in_hs)       hold  <= {w0, s.iInData};
    end
`else
  logic unused_iv;
  assign unused_iv = ^{iIvLoad, iIv0, iIv1};
  assign chain_x   = '0;
  assign res       = {iC0, iC1};
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w0   <= '0;
      mode <= 1'b0;
      oV0  <= '0;
      oV1  <= '0;
      r0   <= '0;
      r1   <= '0;
      cnt  <= '0;
    end else begin
      if (state == ST_GET0 && in_hs) begin
        w0   <= s.iInData;
        mode <= iMode;
      end
      if (state == ST_GET1 && in_hs) {oV0, oV1} <= {w0, s.iInData} ^ chain_x;
      if (state == ST_RUN && iCoreDone) {r0, r1} <= res;
      // saturating: a hung core must not wrap back below the limit
      if (state == ST_GET1 && in_hs) cnt <= '0;
      else if ((state == ST_RUN || state == ST_DRAIN) && cnt != CW'(LIMIT))
        cnt <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_tea_cbc_ctrl.sv
// Bench for tea_cbc_ctrl: behavioural TEA core, block-level CBC/ECB model and output scoreboard.
module tb_tea_cbc_ctrl;
  localparam logic [31:0] DELTA = 32'h9e3779b9;
  localparam int          WD    = 4 * 32 + 16;
  localparam logic [127:0] KEY  = {32'h132acf42, 32'h234acb45, 32'h3235acbe, 32'h4533f235};

  logic        clk = 1'b0, rst = 1'b0;
  logic        key_we = 1'b0, iv_load = 1'b0, in_mode = 1'b0;
  logic [1:0]  key_waddr = 2'd0;
  logic [31:0] key_wdata = '0, iv0 = '0, iv1 = '0;
  logic [31:0] v0, v1, key_sub, c0, c1;
  logic        st_c, st_d, core_done, busy, err;
  logic [1:0]  core_kaddr;

  tea_cbc_ctrl_if #(.WORD_SIZE(32)) bus ();

  tea_cbc_ctrl dut (
    .clk(clk), .rst(rst), .iKeyWe(key_we), .iKeyAddr(key_waddr), .iKeyData(key_wdata),
    .iIvLoad(iv_load), .iIv0(iv0), .iIv1(iv1), .iMode(in_mode), .s(bus),
    .oV0(v0), .oV1(v1), .oStartCipher(st_c), .oStartDecipher(st_d),
    .iKeyAddress(core_kaddr), .oKeySub(key_sub), .iC0(c0), .iC1(c1),
    .iCoreDone(core_done), .oBusy(busy), .oError(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_fail = 0, n_push = 0, n_got = 0;
  logic [31:0] expq[$];
  logic [127:0] mk = '0;
  logic [63:0]  mchain = '0;
  bit           core_hang = 1'b0;

  function automatic logic [63:0] tea_enc_n(input logic [63:0] v, input logic [127:0] k, input int n);
    logic [31:0] y, z, sum;
    y = v[63:32]; z = v[31:0]; sum = '0;
    for (int i = 0; i < n; i++) begin
      sum += DELTA;
      y += ((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]);
      z += ((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]);
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] tea_dec_n(input logic [63:0] v, input logic [127:0] k, input int n);
    logic [31:0] y, z, sum;
    y = v[63:32]; z = v[31:0]; sum = DELTA * 32'(n);
    for (int i = 0; i < n; i++) begin
      z -= ((y << 4) + k[63:32]) ^ (y + sum) ^ ((y >> 5) + k[31:0]);
      y -= ((z << 4) + k[127:96]) ^ (z + sum) ^ ((z >> 5) + k[95:64]);
      sum -= DELTA;
    end
    return {y, z};
  endfunction

  // Block-level expectation: what the result pair must be, updating the model chain.
  function automatic logic [63:0] model_block(input logic [31:0] a, input logic [31:0] b, input logic m);
    logic [63:0] x, r;
    x = {a, b};
`ifdef TEA_CBC_CHAIN_EN
    if (!m) begin r = tea_enc_n(x ^ mchain, mk, 32); mchain = r; end
    else    begin r = tea_dec_n(x, mk, 32) ^ mchain; mchain = x; end
`else
    r = m ? tea_dec_n(x, mk, 32) : tea_enc_n(x, mk, 32);
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expired(input string nm);
    n_cmp++; n_fail++;
    $display("FAIL %s: wait bound expired, event not seen", nm);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Behavioural core: fetches the 4 keys through the key port, then answers after a few cycles.
  initial begin
    logic [63:0]  cv;
    logic [127:0] ck;
    logic         cdec;
    core_done = 1'b0; core_kaddr = 2'd0; c0 = '0; c1 = '0;
    forever begin
      @(negedge clk);
      if (rst && (st_c || st_d)) begin
        cdec = st_d; cv = {v0, v1};
        for (int k = 0; k < 4; k++) begin
          core_kaddr = 2'(k); #1;
          ck[127-32*k -: 32] = key_sub;
          @(negedge clk);
        end
        repeat (3) @(negedge clk);
        if (!core_hang) begin
          {c0, c1} = cdec ? tea_dec_n(cv, ck, 32) : tea_enc_n(cv, ck, 32);
          core_done = 1'b1;
          while (st_c || st_d) @(negedge clk);
          repeat (3) @(negedge clk);
          core_done = 1'b0;
        end else begin
          while (rst && (st_c || st_d)) @(negedge clk);
        end
      end
    end
  end

  // Scoreboard: every accepted output word is checked against the model queue.
  always @(negedge clk) begin
    if (rst && bus.oOutValid && bus.iOutReady) begin
      n_got++;
      if (expq.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL out_extra: got %h expected no word", bus.oOutData);
      end else begin
        check("out_word", {32'h0, bus.oOutData}, {32'h0, expq.pop_front()});
      end
    end
  end

  task automatic put_word(input logic [31:0] w, input logic m);
    int t;
    t = 0;
    bus.iInValid = 1'b1; bus.iInData = w; in_mode = m;
    while (!bus.oInReady && t < 400) begin tick(); t++; end
    if (t >= 400) expired("in_ready");
    tick();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic m,
                      input bit has_exp, input logic [63:0] e, output logic [63:0] r);
    r = model_block(a, b, m);
    if (has_exp) r = e;
    expq.push_back(r[63:32]); expq.push_back(r[31:0]); n_push += 2;
    put_word(a, m); put_word(b, m);
    bus.iInValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((expq.size() != 0 || busy) && t < 1000) begin tick(); t++; end
    if (t >= 1000) expired("idle");
  endtask

  task automatic write_keys(input logic [127:0] k, input bit model);
    for (int i = 0; i < 4; i++) begin
      key_we = 1'b1; key_waddr = 2'(i); key_wdata = k[127-32*i -: 32];
      tick();
    end
    key_we = 1'b0;
    if (model) mk = k;
  endtask

  task automatic load_iv(input logic [31:0] a, input logic [31:0] b, input bit model);
    iv_load = 1'b1; iv0 = a; iv1 = b;
    tick();
    iv_load = 1'b0;
`ifdef TEA_CBC_CHAIN_EN
    if (model) mchain = {a, b};
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time bound reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    logic [63:0] r, ct[3];
    logic [63:0] pt[3];
    pt[0] = 64'h0123456789abcdef; pt[1] = 64'hfedcba9876543210; pt[2] = 64'h00000000ffffffff;
    bus.iInValid = 1'b0; bus.iInData = '0; bus.iOutReady = 1'b1;

    // model pins, one TEA round by hand with an all-zero key
    check("pin_enc1", tea_enc_n(64'h0, 128'h0, 1), 64'h9e3779b9dbe8d32f);
    check("pin_dec1", tea_dec_n(64'h9e3779b9dbe8d32f, 128'h0, 1), 64'h0);

    repeat (2) tick();
    check("rst_ctrl", {58'h0, bus.oInReady, bus.oOutValid, st_c, st_d, busy, err}, 64'h0);
    check("rst_v", {v0, v1}, 64'h0);
    check("rst_data", {bus.oOutData, key_sub}, 64'h0);
    rst = 1'b1;
    tick();

    // 1: single encrypt, chain at reset value
    write_keys(KEY, 1);
    send(32'h3d45f7a7, 32'h235fcb21, 1'b0, 0, '0, r);
    wait_idle();
    check("s1_err", {63'h0, err}, 64'h0);

    // 2: IV=0 reproduces the first block; IV={0,1} flips the low bit of V1
    load_iv(32'h0, 32'h0, 1);
    send(32'h3d45f7a7, 32'h235fcb21, 1'b0, 0, '0, r);
    wait_idle();
    load_iv(32'h0, 32'h1, 1);
`ifdef TEA_CBC_CHAIN_EN
    send(32'h3d45f7a7, 32'h235fcb21, 1'b0, 1, tea_enc_n({32'h3d45f7a7, 32'h235fcb21 ^ 32'h1}, KEY, 32), r);
`else
    send(32'h3d45f7a7, 32'h235fcb21, 1'b0, 0, '0, r);
`endif
    wait_idle();

    // 3: three streamed encrypts, then decrypt them back to the plaintext
    load_iv(32'hcafef00d, 32'h12345678, 1);
    for (int i = 0; i < 3; i++) begin
      send(pt[i][63:32], pt[i][31:0], 1'b0, 0, '0, r);
      ct[i] = r;
    end
    wait_idle();
    load_iv(32'hcafef00d, 32'h12345678, 1);
    for (int i = 0; i < 3; i++) send(ct[i][63:32], ct[i][31:0], 1'b1, 1, pt[i], r);
    wait_idle();

    // 4: downstream stall in PUT0 with the next word already offered
    send(32'h11112222, 32'h33334444, 1'b0, 0, '0, r);
    bus.iOutReady = 1'b0;
    begin
      int t;
      t = 0;
      while (!bus.oOutValid && t < 300) begin tick(); t++; end
      if (t >= 300) expired("out_valid");
    end
    bus.iInValid = 1'b1; bus.iInData = 32'h55556666; in_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("stall_data", {31'h0, bus.oOutValid, bus.oOutData}, {31'h0, 1'b1, expq[0]});
      check("stall_inrdy", {63'h0, bus.oInReady}, 64'h0);
      tick();
    end
    bus.iOutReady = 1'b1;
    send(32'h55556666, 32'h77778888, 1'b0, 0, '0, r);
    wait_idle();
    check("s4_count", 64'(n_got), 64'(n_push));

    // 5: key and IV writes while busy are dropped
    send(32'h9abcdef0, 32'h13579bdf, 1'b0, 0, '0, r);
    write_keys(~KEY, 0);
    load_iv(32'hffffffff, 32'hffffffff, 0);
    wait_idle();
    send(32'h2468ace0, 32'h0f0f0f0f, 1'b1, 0, '0, r);
    wait_idle();

    // 6: hung core trips the watchdog; reset clears everything
    core_hang = 1'b1;
    put_word(32'hdeadbeef, 1'b0); put_word(32'h01020304, 1'b0);
    bus.iInValid = 1'b1;
    repeat (WD - 1) tick();
    check("wdog_early", {63'h0, err}, 64'h0);
    tick();
    check("wdog_fire", {63'h0, err}, 64'h1);
    check("err_outs", {59'h0, bus.oInReady, bus.oOutValid, st_c, st_d, busy}, 64'h1);
    rst = 1'b0; #1;
    check("arst_ctrl", {58'h0, bus.oInReady, bus.oOutValid, st_c, st_d, busy, err}, 64'h0);
    check("arst_v", {v0, v1}, 64'h0);
    check("arst_data", {bus.oOutData, key_sub}, 64'h0);
    core_hang = 1'b0; bus.iInValid = 1'b0;
    repeat (3) tick();
    rst = 1'b1; mk = '0; mchain = '0;
    tick();
    write_keys(KEY, 1);
    send(32'h3d45f7a7, 32'h235fcb21, 1'b0, 0, '0, r);
    wait_idle();
    check("final_err", {63'h0, err}, 64'h0);
    check("final_count", 64'(n_got), 64'(n_push));
    check("final_q", 64'(expq.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
